// File: rtl/cpu_oam_dma.sv
// Sprite DMA: a CPU write to the page register halts the CPU and copies LEN bytes
// from {page, idx} into OAM. Define OAM_DMA_PARITY_ALIGN_EN to add odd-cycle alignment.
module cpu_oam_dma #(
   parameter int                ADDR_W        = 16,
   parameter int                DATA_W        = 8,
   parameter int                LEN           = 256,
   parameter int                DEST_W        = 8,
   parameter logic [ADDR_W-1:0] PAGE_REG_ADDR = 16'h4014
) (
   input  logic              mainClk,
   input  logic              reset,
   input  logic              cpuCe,
   input  logic [ADDR_W-1:0] busAddr,
   input  logic [DATA_W-1:0] busWrData,
   input  logic              busWe,
   input  logic [DEST_W-1:0] oamStart,
   output logic              cpuHalt,
   output logic [ADDR_W-1:0] dmaAddr,
   output logic              dmaRd,
   input  logic [DATA_W-1:0] dmaRdData,
   output logic [DEST_W-1:0] oamAddr,
   output logic [DATA_W-1:0] oamWrData,
   output logic              oamWe,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = $clog2(LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_align;
   logic              w_last;
   logic [IDX_W-1:0]  w_idx_inc;

   logic [DATA_W-1:0] r_page;
   logic [DEST_W-1:0] r_base;
   logic [IDX_W-1:0]  r_idx;
   logic              r_cpuHalt;
   logic              r_busy;
   logic              r_done;
   logic              r_dmaRd;
   logic [ADDR_W-1:0] r_dmaAddr;
   logic [DEST_W-1:0] r_oamAddr;
   logic [DATA_W-1:0] r_oamWrData;

`ifdef OAM_DMA_PARITY_ALIGN_EN
   logic r_parity;

   always_ff @(posedge mainClk) begin
      if (reset)
         r_parity <= 1'b0;
      else if (cpuCe)
         r_parity <= ~r_parity;
   end
`endif

   assign w_last    = (r_idx == IDX_W'(LEN - 1));
   assign w_idx_inc = r_idx + IDX_W'(1);

   always_comb begin
      w_next  = r_state;
      w_align = 1'b0;
`ifdef OAM_DMA_PARITY_ALIGN_EN
      w_align = r_parity;
`endif
      case (r_state)
         S_IDLE:  if (busWe && (busAddr == PAGE_REG_ADDR)) w_next = S_HALT;
         S_HALT:  w_next = w_align ? S_ALIGN : S_READ;
         S_ALIGN: w_next = S_READ;
         S_READ:  w_next = S_WRITE;
         S_WRITE: w_next = w_last ? S_IDLE : S_READ;
         default: w_next = S_IDLE;
      endcase
   end

   // All state moves on CPU ticks only; done is cleared every mainClk so it is one clock wide.
   always_ff @(posedge mainClk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_page      <= '0;
         r_base      <= '0;
         r_idx       <= '0;
         r_cpuHalt   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_dmaRd     <= 1'b0;
         r_dmaAddr   <= '0;
         r_oamAddr   <= '0;
         r_oamWrData <= '0;
      end else begin
         r_done <= 1'b0;
         if (cpuCe) begin
            r_state   <= w_next;
            r_cpuHalt <= (w_next != S_IDLE);
            r_busy    <= (w_next != S_IDLE);
            r_dmaRd   <= (w_next == S_READ);
            r_done    <= (r_state == S_WRITE) && w_last;
            case (r_state)
               S_IDLE: begin
                  if (w_next == S_HALT) begin
                     r_page <= busWrData;
                     r_base <= oamStart;
                     r_idx  <= '0;
                  end
               end
               S_HALT, S_ALIGN: begin
                  if (w_next == S_READ)
                     r_dmaAddr <= ADDR_W'({r_page, r_idx});
               end
               S_READ: begin
                  r_oamWrData <= dmaRdData;
                  r_oamAddr   <= r_base + DEST_W'(r_idx);
               end
               S_WRITE: begin
                  r_idx <= w_idx_inc;
                  if (!w_last)
                     r_dmaAddr <= ADDR_W'({r_page, w_idx_inc});
               end
               default: ;
            endcase
         end
      end
   end

   assign cpuHalt   = r_cpuHalt;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dmaRd     = r_dmaRd;
   assign dmaAddr   = r_dmaAddr;
   assign oamAddr   = r_oamAddr;
   assign oamWrData = r_oamWrData;
   assign oamWe     = (r_state == S_WRITE) && cpuCe;

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Bench for cpu_oam_dma: a 256-byte instance (cpuCe every 2nd clock) and a LEN=4/DEST_W=6
// instance (cpuCe every 3rd clock), each with a source-memory model and an OAM write scoreboard.
module tb_cpu_oam_dma;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [7:0] src(input logic [15:0] a);
      return a[7:0] ^ 8'h58 ^ a[15:8];
   endfunction

   // ---------------- instance A: default parameters
   logic        ceA = 1'b0, busWeA = 1'b0;
   logic [15:0] busAddrA = '0;
   logic [7:0]  busWrDataA = '0, oamStartA = '0;
   logic        cpuHaltA, dmaRdA, oamWeA, busyA, doneA;
   logic [15:0] dmaAddrA;
   logic [7:0]  dmaRdDataA, oamAddrA, oamWrDataA;
   assign dmaRdDataA = src(dmaAddrA);

   cpu_oam_dma dut_a (
      .mainClk(clk), .reset(reset), .cpuCe(ceA), .busAddr(busAddrA),
      .busWrData(busWrDataA), .busWe(busWeA), .oamStart(oamStartA),
      .cpuHalt(cpuHaltA), .dmaAddr(dmaAddrA), .dmaRd(dmaRdA), .dmaRdData(dmaRdDataA),
      .oamAddr(oamAddrA), .oamWrData(oamWrDataA), .oamWe(oamWeA), .busy(busyA), .done(doneA)
   );

   // ---------------- instance B: LEN=4, DEST_W=6
   logic        ceB = 1'b0, busWeB = 1'b0;
   logic [15:0] busAddrB = '0;
   logic [7:0]  busWrDataB = '0;
   logic [5:0]  oamStartB = '0;
   logic        cpuHaltB, dmaRdB, oamWeB, busyB, doneB;
   logic [15:0] dmaAddrB;
   logic [7:0]  dmaRdDataB, oamWrDataB;
   logic [5:0]  oamAddrB;
   assign dmaRdDataB = src(dmaAddrB);

   cpu_oam_dma #(.LEN(4), .DEST_W(6)) dut_b (
      .mainClk(clk), .reset(reset), .cpuCe(ceB), .busAddr(busAddrB),
      .busWrData(busWrDataB), .busWe(busWeB), .oamStart(oamStartB),
      .cpuHalt(cpuHaltB), .dmaAddr(dmaAddrB), .dmaRd(dmaRdB), .dmaRdData(dmaRdDataB),
      .oamAddr(oamAddrB), .oamWrData(oamWrDataB), .oamWe(oamWeB), .busy(busyB), .done(doneB)
   );

`ifdef OAM_DMA_PARITY_ALIGN_EN
   localparam int ALIGN = 1;
`else
   localparam int ALIGN = 0;
`endif

   // Enable generation plus a model of the parity register each DUT holds.
   int   divA = 0, divB = 0;
   logic parA_m = 1'b0, parB_m = 1'b0;
   always @(posedge clk) begin
      if (reset) parA_m = 1'b0; else if (ceA) parA_m = ~parA_m;
      if (reset) parB_m = 1'b0; else if (ceB) parB_m = ~parB_m;
      #1;
      divA = (divA + 1) % 2;
      ceA  = (divA == 0);
      divB = (divB + 1) % 3;
      ceB  = (divB == 0);
   end

   // ---------------- scoreboards and monitors (sample at negedge)
   logic [15:0] exp_qA[$];
   logic [15:0] exp_qB[$];
   logic [15:0] e;
   logic [15:0] eb;
   int   haltA, rdA, wrA, doneA_cnt, haltB, rdB, wrB, doneB_cnt;
   logic [7:0] pageA_exp, pageB_exp;
   logic prev_weA = 1'b0, prev_weB = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (oamWeA) begin
            wrA++;
            n_vec++;
            if (exp_qA.size() == 0) begin
               n_err++;
               $display("FAIL oamA_extra: got addr=%h data=%h, required no write", oamAddrA, oamWrDataA);
            end else begin
               e = exp_qA.pop_front();
               if ({oamAddrA, oamWrDataA} !== e) begin
                  n_err++;
                  $display("FAIL oamA_write: got addr=%h data=%h, required addr=%h data=%h",
                           oamAddrA, oamWrDataA, e[15:8], e[7:0]);
               end
            end
            if (prev_weA) begin
               n_err++;
               $display("FAIL oamA_width: oamWe high on consecutive clocks");
            end
         end
         if (dmaRdA && ceA) begin
            n_vec++;
            if (dmaAddrA[15:8] !== pageA_exp) begin
               n_err++;
               $display("FAIL dmaA_page: got %h, required %h", dmaAddrA[15:8], pageA_exp);
            end
         end
         if (ceA && cpuHaltA) begin
            if (dmaRdA && rdA < 0) rdA = haltA;
            haltA++;
         end
         if (doneA) begin
            doneA_cnt++;
            n_vec++;
            if (cpuHaltA !== 1'b0) begin
               n_err++;
               $display("FAIL doneA_halt: cpuHalt=%b at done, required 0", cpuHaltA);
            end
         end
         if (oamWeB) begin
            wrB++;
            n_vec++;
            if (exp_qB.size() == 0) begin
               n_err++;
               $display("FAIL oamB_extra: got addr=%h data=%h, required no write", oamAddrB, oamWrDataB);
            end else begin
               eb = exp_qB.pop_front();
               if ({2'b00, oamAddrB, oamWrDataB} !== eb) begin
                  n_err++;
                  $display("FAIL oamB_write: got addr=%h data=%h, required addr=%h data=%h",
                           oamAddrB, oamWrDataB, eb[13:8], eb[7:0]);
               end
            end
            if (prev_weB) begin
               n_err++;
               $display("FAIL oamB_width: oamWe high on consecutive clocks");
            end
         end
         if (dmaRdB && ceB) begin
            n_vec++;
            if (dmaAddrB !== {6'b0, pageB_exp, 2'b00} + {14'b0, dmaAddrB[1:0]}) begin
               n_err++;
               $display("FAIL dmaB_addr: got %h, required page %h", dmaAddrB, pageB_exp);
            end
         end
         if (ceB && cpuHaltB) begin
            if (dmaRdB && rdB < 0) rdB = haltB;
            haltB++;
         end
         if (doneB) doneB_cnt++;
      end
      prev_weA = oamWeA;
      prev_weB = oamWeB;
   end

   // ---------------- driver tasks
   // trig_par is the parity the DUT holds at the trigger edge; trig_par=1 means no alignment.
   task automatic trigger_a(input logic [7:0] page, input logic [7:0] start, input logic trig_par);
      int n = 0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do begin
         @(negedge clk);
         n++;
      end while (!(ceA && parA_m == trig_par) && n < 100);
      busAddrA = 16'h4014; busWrDataA = page; oamStartA = start; busWeA = 1'b1;
      @(negedge clk);
      busWeA = 1'b0; busAddrA = '0;
      n_vec++;
      if (cpuHaltA !== 1'b1) begin
         n_err++;
         $display("FAIL haltA_rise: cpuHalt=%b after trigger edge, required 1", cpuHaltA);
      end
   endtask

   task automatic wait_idle_a();
      int n = 0;
      while (busyA && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         n_err++;
         $display("FAIL timeoutA: busy still 1 after %0d clocks, required 0", n);
      end
      @(negedge clk);
   endtask

   task automatic expect_a(input logic [7:0] page, input logic [7:0] start);
      for (int i = 0; i < 256; i++)
         exp_qA.push_back({8'(start + 8'(i)), src({page, 8'(i)})});
      haltA = 0; rdA = -1; wrA = 0; doneA_cnt = 0; pageA_exp = page;
   endtask

   task automatic check_a(input string name, input int ticks, input int first_rd);
      n_vec += 4;
      if (haltA !== ticks) begin
         n_err++; $display("FAIL %s_ticks: got %0d, required %0d", name, haltA, ticks);
      end
      if (rdA !== first_rd) begin
         n_err++; $display("FAIL %s_first_rd: got %0d, required %0d", name, rdA, first_rd);
      end
      if (wrA !== 256 || exp_qA.size() != 0) begin
         n_err++; $display("FAIL %s_writes: got %0d, required 256", name, wrA);
      end
      if (doneA_cnt !== 1) begin
         n_err++; $display("FAIL %s_done: got %0d pulses, required 1", name, doneA_cnt);
      end
   endtask

   // ---------------- tests
   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_vec += 3;
      if ({cpuHaltA, busyA, doneA, dmaRdA, oamWeA} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b, required 00000", {cpuHaltA, busyA, doneA, dmaRdA, oamWeA});
      end
      if ({dmaAddrA, oamAddrA, oamWrDataA} !== 32'h0) begin
         n_err++; $display("FAIL reset_data: got %h, required 0", {dmaAddrA, oamAddrA, oamWrDataA});
      end
      if ({cpuHaltB, busyB, doneB, dmaRdB, oamWeB} !== 5'b0) begin
         n_err++; $display("FAIL resetB_ctrl: got %b, required 00000", {cpuHaltB, busyB, doneB, dmaRdB, oamWeB});
      end
   endtask

   task automatic test_ignore_no_ce();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ceA && n < 10);
      busAddrA = 16'h4014; busWrDataA = 8'h02; busWeA = 1'b1;
      @(negedge clk);
      busWeA = 1'b0; busAddrA = '0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (busyA !== 1'b0) begin
         n_err++; $display("FAIL no_ce_trigger: busy=%b, required 0", busyA);
      end
   endtask

   task automatic test_even();
      expect_a(8'h02, 8'h00);
      trigger_a(8'h02, 8'h00, 1'b1);
      wait_idle_a();
      check_a("even", 513, 1);
   endtask

   task automatic test_odd();
      expect_a(8'h02, 8'h00);
      trigger_a(8'h02, 8'h00, 1'b0);
      wait_idle_a();
      check_a("odd", 513 + ALIGN, 1 + ALIGN);
   endtask

   task automatic test_wrap_retrigger();
      int n = 0;
      expect_a(8'h03, 8'hF0);
      trigger_a(8'h03, 8'hF0, 1'b1);
      while (wrA < 100 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      do begin
         @(negedge clk);
         n++;
      end while (!ceA && n < 2100);
      busAddrA = 16'h4014; busWrDataA = 8'h07; busWeA = 1'b1;
      @(negedge clk);
      busWeA = 1'b0; busAddrA = '0;
      wait_idle_a();
      check_a("wrap", 513, 1);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int w;
      expect_a(8'h02, 8'h00);
      trigger_a(8'h02, 8'h00, 1'b1);
      while (wrA < 40 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++;
      if ({cpuHaltA, busyA, oamWeA} !== 3'b000) begin
         n_err++; $display("FAIL reset_mid: halt/busy/we=%b, required 000", {cpuHaltA, busyA, oamWeA});
      end
      exp_qA.delete();
      w = wrA;
      repeat (20) @(negedge clk);
      n_vec++;
      if (wrA !== w) begin
         n_err++; $display("FAIL reset_mid_we: got %0d writes after reset, required 0", wrA - w);
      end
      expect_a(8'h02, 8'h00);
      trigger_a(8'h02, 8'h00, 1'b1);
      wait_idle_a();
      check_a("restart", 513, 1);
   endtask

   task automatic run_b(input logic trig_par, input int ticks);
      int n = 0;
      for (int i = 0; i < 4; i++)
         exp_qB.push_back({2'b00, 6'(6'h3E + 6'(i)), src({6'b0, 8'h11, 2'(i)})});
      haltB = 0; rdB = -1; wrB = 0; doneB_cnt = 0; pageB_exp = 8'h11;
      do begin
         @(negedge clk);
         n++;
      end while (!(ceB && parB_m == trig_par) && n < 100);
      busAddrB = 16'h4014; busWrDataB = 8'h11; oamStartB = 6'h3E; busWeB = 1'b1;
      @(negedge clk);
      busWeB = 1'b0; busAddrB = '0;
      n = 0;
      while (busyB && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      n_vec += 3;
      if (haltB !== ticks) begin
         n_err++; $display("FAIL len4_ticks: got %0d, required %0d", haltB, ticks);
      end
      if (wrB !== 4 || exp_qB.size() != 0) begin
         n_err++; $display("FAIL len4_writes: got %0d, required 4", wrB);
      end
      if (doneB_cnt !== 1) begin
         n_err++; $display("FAIL len4_done: got %0d pulses, required 1", doneB_cnt);
      end
   endtask

   task automatic test_len4();
      run_b(1'b1, 9);
      run_b(1'b0, 9 + ALIGN);
   endtask

   initial begin
      test_reset();
      test_ignore_no_ce();
      test_even();
      test_odd();
      test_wrap_retrigger();
      test_reset_mid();
      test_len4();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
